// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI target engine
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Leading edge is rising when cpol=0; sampling uses it when cpha=0.
    function automatic logic sample_on_rise(input spi_mode_t m);
        return ~(m.cpol ^ m.cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI target engine, all four CPOL/CPHA modes, oversampled in clk
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] si_data,
    output logic                  si_done,
    input  logic [DATA_WIDTH-1:0] so_data,
    input  logic                  so_start,
    output logic                  so_ready
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .reset(reset),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .reset(reset),
        .din  (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_s;

    state_t                 state_q, state_d;
    spi_mode_t              mode_q, mode_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rx_q, rx_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [DATA_WIDTH-1:0]  buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0]  si_data_q, si_data_d;
    logic                   si_done_q, si_done_d;
    logic                   miso_q, miso_d;
    logic                   sample_edge, shift_edge, consume;

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sample_edge = sample_on_rise(mode_q) ? sclk_rise : sclk_fall;
    assign shift_edge  = sample_on_rise(mode_q) ? sclk_fall : sclk_rise;

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        si_data_d   = si_data_q;
        si_done_d   = 1'b0;
        miso_d      = miso_q;
        consume     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    mode_d.cpol = cpol;
                    mode_d.cpha = cpha;
                    miso_d      = 1'b0;
                    tx_d        = buf_full_q ? buf_q : '0;
                    consume     = buf_full_q;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rx_d    = '0;
                end else if (sample_edge) begin
                    rx_d = {rx_q[DATA_WIDTH-2:0], mosi_s};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d     = '0;
                        si_data_d = rx_d;
                        si_done_d = 1'b1;
                        tx_d      = buf_full_q ? buf_q : '0;
                        consume   = buf_full_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (shift_edge) begin
                    // cpha=0: the trailing edge right after a wrap must not disturb the freshly reloaded byte.
                    if (mode_q.cpha) begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = tx_q << 1;
                    end else if (cnt_q != '0) begin
                        tx_d = tx_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (consume) begin
            buf_full_d = 1'b0;
        end else if (so_start && !buf_full_q) begin
            buf_d      = so_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            mode_q      <= '0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            si_data_q   <= '0;
            si_done_q   <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            si_data_q   <= si_data_d;
            si_done_q   <= si_done_d;
            miso_q      <= miso_d;
        end
    end

    assign miso     = (state_q == ACTIVE) ? (mode_q.cpha ? miso_q : tx_q[DATA_WIDTH-1]) : 1'b0;
    assign si_data  = si_data_q;
    assign si_done  = si_done_q;
    assign so_ready = ~buf_full_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - directed bench for spi_slave_core with a bit-banged master
module tb_spi_slave_core;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset, cpol, cpha, sclk, mosi, cs, miso, si_done, so_start, so_ready;
    logic [7:0] si_data, so_data;

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .cpol    (cpol),
        .cpha    (cpha),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs      (cs),
        .miso    (miso),
        .si_data (si_data),
        .si_done (si_done),
        .so_data (so_data),
        .so_start(so_start),
        .so_ready(so_ready)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    logic [7:0] done_q[$];

    always @(posedge clk) begin
        #1;
        if (reset === 1'b1 && si_done === 1'b1) begin
            done_cnt++;
            done_q.push_back(si_data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_done(input int i);
        if (i < done_q.size()) return done_q[i];
        return 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic so_load(input logic [7:0] b);
        int k = 0;
        while (!so_ready && k < 200) begin
            tick(1);
            k++;
        end
        check("so_ready_wait", {31'd0, so_ready}, 32'd1);
        so_data  = b;
        so_start = 1'b1;
        tick(1);
        so_start = 1'b0;
    endtask

    task automatic set_mode(input logic p, input logic h);
        cs   = 1'b1;
        cpol = p;
        cpha = h;
        sclk = p;
        tick(8);
    endtask

    task automatic xfer(input logic [7:0] mtx, input int nbits, output logic [7:0] mrx);
        mrx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mtx[7-i];
                tick(H);
                mrx  = {mrx[6:0], miso};
                sclk = ~sclk;
                tick(H);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = mtx[7-i];
                tick(H);
                mrx  = {mrx[6:0], miso};
                sclk = ~sclk;
                tick(H);
            end
        end
    endtask

    task automatic end_frame();
        tick(H);
        cs = 1'b1;
        tick(H);
    endtask

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       pre;
        logic [7:0] so_b;
        logic [7:0] mtx;
        logic [7:0] si_exp;
        logic [7:0] mrx_exp;
    } vec_t;

    vec_t       vt[6];
    logic [7:0] r0, r1;
    int         d0;

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b1, 8'hAA, 8'hF0, 8'hF0, 8'hAA};
        vt[1] = '{1'b1, 1'b1, 1'b1, 8'h55, 8'h0F, 8'h0F, 8'h55};
        vt[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hC3, 8'hC3, 8'h00};
        vt[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 8'hC3, 8'h00};
        vt[4] = '{1'b0, 1'b1, 1'b1, 8'h96, 8'h69, 8'h69, 8'h96};
        vt[5] = '{1'b1, 1'b0, 1'b1, 8'h3A, 8'hE1, 8'hE1, 8'h3A};

        reset = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
        cs = 1'b1; so_start = 1'b0; so_data = 8'h00;
        tick(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_si_data", {24'd0, si_data}, 32'd0);
        check("rst_si_done", {31'd0, si_done}, 32'd0);
        check("rst_so_ready", {31'd0, so_ready}, 32'd1);
        reset = 1'b1;
        tick(2);

        for (int v = 0; v < 6; v++) begin
            set_mode(vt[v].cpol, vt[v].cpha);
            d0 = done_cnt;
            if (vt[v].pre) begin
                so_load(vt[v].so_b);
                so_data  = ~vt[v].so_b;
                so_start = 1'b1;
                tick(1);
                so_start = 1'b0;
            end
            check($sformatf("v%0d_so_ready_pre", v), {31'd0, so_ready}, {31'd0, !vt[v].pre});
            cs = 1'b0;
            tick(H);
            xfer(vt[v].mtx, 8, r0);
            end_frame();
            check($sformatf("v%0d_si_data", v), {24'd0, si_data}, {24'd0, vt[v].si_exp});
            check($sformatf("v%0d_done_cnt", v), done_cnt - d0, 32'd1);
            check($sformatf("v%0d_master_rx", v), {24'd0, r0}, {24'd0, vt[v].mrx_exp});
            check($sformatf("v%0d_so_ready_post", v), {31'd0, so_ready}, 32'd1);
            check($sformatf("v%0d_miso_idle", v), {31'd0, miso}, 32'd0);
        end

        set_mode(1'b0, 1'b0);
        d0 = done_cnt;
        so_load(8'h12);
        cs = 1'b0;
        tick(H);
        fork
            begin
                xfer(8'hA5, 8, r0);
                xfer(8'h5A, 8, r1);
            end
            so_load(8'h34);
        join
        end_frame();
        check("b2b_done_cnt", done_cnt - d0, 32'd2);
        check("b2b_si0", {24'd0, get_done(d0)}, 32'h A5);
        check("b2b_si1", {24'd0, get_done(d0 + 1)}, 32'h5A);
        check("b2b_mrx0", {24'd0, r0}, 32'h12);
        check("b2b_mrx1", {24'd0, r1}, 32'h34);

        d0 = done_cnt;
        cs = 1'b0;
        tick(H);
        xfer(8'hFF, 3, r0);
        end_frame();
        check("partial_no_done", done_cnt - d0, 32'd0);
        check("partial_si_keep", {24'd0, si_data}, 32'h5A);
        cs = 1'b0;
        tick(H);
        xfer(8'h81, 8, r0);
        end_frame();
        check("after_partial_si", {24'd0, si_data}, 32'h81);
        check("after_partial_done", done_cnt - d0, 32'd1);

        so_load(8'hFF);
        cs = 1'b0;
        tick(H);
        so_load(8'h77);
        xfer(8'hE0, 4, r0);
        check("pre_reset_miso", {31'd0, miso}, 32'd1);
        check("pre_reset_so_ready", {31'd0, so_ready}, 32'd0);
        reset = 1'b0;
        tick(1);
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_si_data", {24'd0, si_data}, 32'd0);
        check("midrst_so_ready", {31'd0, so_ready}, 32'd1);
        check("midrst_si_done", {31'd0, si_done}, 32'd0);
        reset = 1'b1;
        cs = 1'b1;
        tick(H);
        d0 = done_cnt;
        cs = 1'b0;
        tick(H);
        xfer(8'h3C, 8, r0);
        end_frame();
        check("post_rst_si", {24'd0, si_data}, 32'h3C);
        check("post_rst_done", done_cnt - d0, 32'd1);
        check("post_rst_mrx", {24'd0, r0}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
SPI target-side engine: the responder to spi_master on the same sclk/mosi/miso/cs link, supporting all four CPOL/CPHA modes.
- sclk, mosi and cs are oversampled in the system clk domain through synchronizers and edge detection.
- Received bytes are delivered as si_data with an si_done strobe.
- Response bytes are accepted through the so_data/so_start/so_ready handshake and shifted out on miso, MSB first.

Parameters:
DATA_WIDTH, 8, bits per SPI frame and width of si_data/so_data
SYNC_STAGES, 2, flip-flop stages on the sclk, mosi and cs inputs (minimum 2)

Ports:
clk       input   1           system clock; all logic on rising edge
reset     input   1           synchronous, active-low reset (asserted when 0)
cpol      input   1           clock polarity; idle sclk level
cpha      input   1           clock phase; 0 = sample on leading edge, 1 = sample on trailing edge
sclk      input   1           SPI clock from master, asynchronous to clk
mosi      input   1           master-out data
cs        input   1           chip select, active low
miso      output  1           slave-out data
si_data   output  DATA_WIDTH  last complete received byte
si_done   output  1           one-cycle strobe: si_data updated
so_data   input   DATA_WIDTH  next response byte
so_start  input   1           load so_data into tx buffer when so_ready=1
so_ready  output  1           tx buffer empty, can accept so_start

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, bit counter 0, shift registers 0, tx buffer empty.
  - Outputs after reset: miso=0, si_data=0, si_done=0, so_ready=1.
  - A reset mid-frame abandons the frame with no si_done.
- Input synchronizing: sclk, mosi and cs each pass SYNC_STAGES flops. Edges are detected against a one-cycle-delayed copy, so an edge is acted on SYNC_STAGES+1 clk cycles after the pin toggles.
- Master timing requirements:
  - sclk high and low times each >= SYNC_STAGES+2 clk cycles.
  - cs-fall to first sclk edge >= SYNC_STAGES+2 clk cycles.
- cpol/cpha are latched on cs fall and held for the whole frame. Changes while cs is low are ignored.
- Edge definitions:
  - Leading edge = rising if cpol=0, falling if cpol=1. Trailing edge = the opposite.
  - Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other one.
- State IDLE (cs high): miso=0, counter held at 0. On synchronized cs fall, go to ACTIVE and load the tx shift register:
  - from the tx buffer if it is full; the buffer empties and so_ready rises the next cycle;
  - with all zeros if the buffer is empty.
- State ACTIVE, miso output:
  - cpha=0: miso = tx MSB, valid immediately after the cs-fall load.
  - cpha=1: miso updates on each shift edge, the first leading edge presenting the MSB.
- State ACTIVE, receive and counting:
  - On every sample edge, shift mosi into the rx register LSB and increment the counter.
  - After the DATA_WIDTH-th sample: si_data <= rx register and si_done=1 for exactly one cycle (the cycle after the edge detect). Counter wraps to 0.
- Back-to-back bytes: within the same cs-low period, the tx shift register is reloaded (buffer or zeros, as at cs fall) at the counter wrap. The next frame continues without cs toggling.
- cs rise while ACTIVE:
  - Return to IDLE in the next cycle and clear the counter and rx register.
  - A partial byte produces no si_done and si_data is unchanged.
  - An unconsumed tx buffer stays full.
- Tx buffer handshake:
  - so_start while so_ready=1 captures so_data; so_ready falls the next cycle.
  - so_start while so_ready=0 is ignored.
  - so_start in the same cycle as a buffer consume: the capture wins for the newly emptied slot only from the following cycle. The late so_start is dropped, and so_ready stays 1.
- sclk edges while cs is high are ignored. Frames are MSB first in both directions.

Decomposition:
- Package spi_pkg holds:
  - state enum typedef (IDLE, ACTIVE);
  - spi_mode_t struct {cpol, cpha};
  - default DATA_WIDTH localparam;
  - helper function deriving the sample/shift edge selection from spi_mode_t.
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiated for sclk and cs; mosi uses the synchronizer only.

Test Plan:
- Mode 0 with spi_master: slave preloads 0xAA via so_start, master sends 0xF0 -> si_data=0xF0 with one si_done pulse, master rx_data=0xAA, so_ready back to 1 after cs fall.
- Mode 3 (cpol=1, cpha=1): slave 0x55, master 0x0F -> si_data=0x0F, master receives 0x55.
- Modes 1 and 2 in turn, no so_start before the frame: master sends 0xC3 -> si_data=0xC3, master receives 0x00.
- Two bytes, cs held low: slave loads 0x12, then 0x34 once so_ready rises; master sends 0xA5, 0x5A -> two si_done pulses with 0xA5 then 0x5A; master receives 0x12, 0x34.
- cs raised after 3 sclk sample edges -> no si_done, si_data keeps its previous value. The next full frame of 0x81 -> si_data=0x81.
- reset driven 0 mid-frame after 4 bits -> next cycle miso=0, si_data=0, so_ready=1, si_done=0. A following full frame of 0x3C is received correctly.
